// File: rtl/vc_buffer.sv
// Multi-VC flit buffer: NUM_VC independent circular FIFOs sharing one write and one read port.
// Define VC_BUFFER_FWFT_EN for a combinational first-word-fall-through read path (default: registered data_out).
module vc_buffer #(
    parameter  int DATA_WIDTH = 8,
    parameter  int RAM_DEPTH  = 8,
    parameter  int NUM_VC     = 2,
    localparam int VW         = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CW         = $clog2(RAM_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [VW-1:0]          wr_vc,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   rd_en,
    input  logic [VW-1:0]          rd_vc,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic [NUM_VC-1:0]      full,
    output logic [NUM_VC-1:0]      empty,
    output logic [NUM_VC*CW-1:0]   count,
    output logic [NUM_VC-1:0]      credit_out,
    output logic                   ovf_err,
    output logic                   udf_err
);

    localparam int PW = $clog2(RAM_DEPTH);
    localparam int NV = 1 << VW;

    logic [DATA_WIDTH-1:0] r_mem    [NUM_VC][RAM_DEPTH];
    logic [PW-1:0]         r_wr_ptr [NUM_VC];
    logic [PW-1:0]         r_rd_ptr [NUM_VC];
    logic [CW-1:0]         r_cnt    [NUM_VC];
    logic [CW-1:0]         w_cnt_nxt[NUM_VC];
    logic [NUM_VC-1:0]     r_full;
    logic [NUM_VC-1:0]     r_empty;
    logic [NUM_VC-1:0]     r_credit;
    logic                  r_ovf;
    logic                  r_udf;

    logic [NV-1:0]         w_full_ext;
    logic [NV-1:0]         w_empty_ext;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [NUM_VC-1:0]     w_wr_hit;
    logic [NUM_VC-1:0]     w_rd_hit;
    logic [DATA_WIDTH-1:0] w_head;

    // Unused VC codes look permanently full and empty, so such accesses are refused and flagged.
    for (genvar g = 0; g < NV; g++) begin : g_status
        if (g < NUM_VC) begin : g_real
            assign w_full_ext[g]  = r_full[g];
            assign w_empty_ext[g] = r_empty[g];
        end else begin : g_oor
            assign w_full_ext[g]  = 1'b1;
            assign w_empty_ext[g] = 1'b1;
        end
    end

    assign w_wr_ok = wr_en & ~w_full_ext[wr_vc];
    assign w_rd_ok = rd_en & ~w_empty_ext[rd_vc];

    // Per-VC accept strobes and head-of-queue mux for the selected read VC.
    always_comb begin
        w_wr_hit = '0;
        w_rd_hit = '0;
        w_head   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_wr_hit[v] = w_wr_ok & (wr_vc == VW'(v));
            w_rd_hit[v] = w_rd_ok & (rd_vc == VW'(v));
            w_head      = w_head | ({DATA_WIDTH{rd_vc == VW'(v)}} & r_mem[v][r_rd_ptr[v]]);
        end
    end

    // Next occupancy per VC; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            w_cnt_nxt[v] = r_cnt[v];
            case ({w_wr_hit[v], w_rd_hit[v]})
                2'b10:   w_cnt_nxt[v] = r_cnt[v] + CW'(1);
                2'b01:   w_cnt_nxt[v] = r_cnt[v] - CW'(1);
                default: w_cnt_nxt[v] = r_cnt[v];
            endcase
        end
    end

    // Pointers, occupancy, status flags, credits and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_cnt[v]    <= '0;
            end
            r_full   <= '0;
            r_empty  <= '1;
            r_credit <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_wr_hit[v]) r_wr_ptr[v] <= r_wr_ptr[v] + PW'(1);
                if (w_rd_hit[v]) r_rd_ptr[v] <= r_rd_ptr[v] + PW'(1);
                r_cnt[v]   <= w_cnt_nxt[v];
                r_full[v]  <= (w_cnt_nxt[v] == CW'(RAM_DEPTH));
                r_empty[v] <= (w_cnt_nxt[v] == CW'(0));
            end
            r_credit <= w_rd_hit;
            r_ovf    <= r_ovf | (wr_en & ~w_wr_ok);
            r_udf    <= r_udf | (rd_en & ~w_rd_ok);
        end
    end

    // Flit storage; intentionally not reset, stale contents are unreachable after pointers clear.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (w_wr_hit[v]) r_mem[v][r_wr_ptr[v]] <= data_in;
        end
    end

`ifdef VC_BUFFER_FWFT_EN
    assign data_out = w_empty_ext[rd_vc] ? '0 : w_head;
`else
    logic [DATA_WIDTH-1:0] r_data_out;

    // Read data register: captures the head flit on an accepted read, holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out <= '0;
        end else if (w_rd_ok) begin
            r_data_out <= w_head;
        end
    end

    assign data_out = r_data_out;
`endif

    for (genvar g = 0; g < NUM_VC; g++) begin : g_count
        assign count[g*CW +: CW] = r_cnt[g];
    end

    assign full       = r_full;
    assign empty      = r_empty;
    assign credit_out = r_credit;
    assign ovf_err    = r_ovf;
    assign udf_err    = r_udf;

endmodule

// File: tb/tb_vc_buffer.sv
// Self-checking bench for vc_buffer (default registered-output build, 8-bit flits, depth 8, 2 VCs).
module tb_vc_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [0:0] wr_vc = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       rd_en = 1'b0;
    logic [0:0] rd_vc = 1'b0;
    logic [7:0] data_out;
    logic [1:0] full;
    logic [1:0] empty;
    logic [7:0] count;
    logic [1:0] credit_out;
    logic       ovf_err;
    logic       udf_err;

    int n_tests  = 0;
    int n_fail   = 0;
    int credits0 = 0;

    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_ovf  = 1'b0;
    logic       m_udf  = 1'b0;
    logic [1:0] m_cred = 2'b00;

    vc_buffer #(.DATA_WIDTH(8), .RAM_DEPTH(8), .NUM_VC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_vc      (wr_vc),
        .data_in    (data_in),
        .rd_en      (rd_en),
        .rd_vc      (rd_vc),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .credit_out (credit_out),
        .ovf_err    (ovf_err),
        .udf_err    (udf_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int msize(input logic v);
        return v ? mq1.size() : mq0.size();
    endfunction

    task automatic check_outputs();
        check_val("data_out", data_out, m_dout);
        check_val("count", count, {4'(mq1.size()), 4'(mq0.size())});
        check_val("full", full, {mq1.size() == 8, mq0.size() == 8});
        check_val("empty", empty, {mq1.size() == 0, mq0.size() == 0});
        check_val("credit", credit_out, m_cred);
        check_val("ovf_err", ovf_err, m_ovf);
        check_val("udf_err", udf_err, m_udf);
    endtask

    // One clock of stimulus: model decides acceptance from pre-edge state, expected read data is queued.
    task automatic step(input logic w, input logic wv, input logic [7:0] d, input logic r, input logic rv);
        logic wok;
        logic rok;
        wr_en = w; wr_vc = wv; data_in = d; rd_en = r; rd_vc = rv;
        wok = w && (msize(wv) < 8);
        rok = r && (msize(rv) > 0);
        m_cred = 2'b00;
        if (rok) begin
            if (rv) exp_q.push_back(mq1.pop_front());
            else    exp_q.push_back(mq0.pop_front());
            m_cred[rv] = 1'b1;
        end
        if (wok) begin
            if (wv) mq1.push_back(d);
            else    mq0.push_back(d);
        end
        if (w && !wok) m_ovf = 1'b1;
        if (r && !rok) m_udf = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        if (rok) m_dout = exp_q.pop_front();
        check_outputs();
        if (credit_out[0]) credits0++;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #2;
        mq0.delete(); mq1.delete(); exp_q.delete();
        m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0; m_cred = 2'b00;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Fill VC0 to full, one dropped write, then drain in order.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h04 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h0C, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_val("credits0", credits0, 32'd8);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Interleaved writes to both VCs, then drain VC1 only.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
            step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check_val("count_iso", count, 8'h03);

        // Simultaneous write and read on a 4-deep VC0.
        step(1'b1, 1'b0, 8'h13, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
        check_val("sim_data", data_out, 8'h10);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_val("fifth_read", data_out, 8'h55);

        // Empty VC1 with write+read, then full VC0 with write+read.
        step(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        check_val("udf_set", udf_err, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
        check_val("cnt_full_wr", count[3:0], 4'd7);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Pointer wrap on VC0, then asynchronous reset with flits stored.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 8'(8'h80 | i), 1'b0, 1'b0);
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
        apply_reset();

        // First access right after reset release, then mixed random traffic.
        step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_buffer.md
VC_BUFFER -- requirements
Module: vc_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, flit width in bits.
REQ-002 SHALL have parameter RAM_DEPTH, default 8, flits per VC; power of two, at least 2.
REQ-003 SHALL have parameter NUM_VC, default 2, number of virtual channels; at least 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port wr_en, input, 1, write request.
REQ-007 SHALL have port wr_vc, input, VW = max(1, $clog2(NUM_VC)), target VC of write.
REQ-008 SHALL have port data_in, input, DATA_WIDTH, write flit.
REQ-009 SHALL have port rd_en, input, 1, read request.
REQ-010 SHALL have port rd_vc, input, VW, source VC of read.
REQ-011 SHALL have port data_out, output, DATA_WIDTH, read flit.
REQ-012 SHALL have ports full and empty, output, NUM_VC each, per-VC status, bit i = VC i.
REQ-013 SHALL have port count, output, NUM_VC*CW with CW = $clog2(RAM_DEPTH+1), per-VC occupancy, VC i in bits [i*CW +: CW].
REQ-014 SHALL have port credit_out, output, NUM_VC, per-VC credit-return pulse.
REQ-015 SHALL have ports ovf_err and udf_err, output, 1 each, sticky overflow and underflow flags.

Function
REQ-016 Each VC SHALL be an independent circular FIFO of RAM_DEPTH entries with its own read pointer, write pointer and count; pointers wrap from RAM_DEPTH-1 to 0.
REQ-017 A write SHALL be accepted iff wr_en=1 and full[wr_vc]=0 at the clock edge; a write to a full VC SHALL be dropped even when a read of the same VC occurs in the same cycle.
REQ-018 A read SHALL be accepted iff rd_en=1 and empty[rd_vc]=0 at the clock edge; a read of an empty VC SHALL be rejected even when a write to the same VC occurs in the same cycle.
REQ-019 Accepted write and accepted read on the same VC in one cycle: both SHALL take effect; count unchanged.
REQ-020 Accepted write and accepted read on different VCs in one cycle SHALL be fully independent.
REQ-021 count, full (count==RAM_DEPTH) and empty (count==0) SHALL be registered and reflect all accepted operations one cycle after the edge.
REQ-022 Default mode: data_out SHALL be registered, load the head flit of rd_vc on the edge of an accepted read (visible next cycle, latency 1), and hold its value otherwise.
REQ-023 credit_out[v] SHALL pulse high for exactly one cycle, in the cycle after an accepted read from VC v.
REQ-024 ovf_err SHALL set on any dropped write; udf_err SHALL set on any rejected read; both SHALL hold until reset.
REQ-025 An out-of-range wr_vc or rd_vc (>= NUM_VC) SHALL be treated as a dropped or rejected access, setting the corresponding error flag.

Reset
REQ-026 rst=0 SHALL asynchronously clear all pointers and counts, set empty to all-ones, clear full, count, credit_out, data_out, ovf_err and udf_err.
REQ-027 Reset asserted mid-burst SHALL discard all stored flits; storage array contents SHALL NOT be reset.
REQ-028 The first access SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 With macro VC_BUFFER_FWFT_EN defined, data_out SHALL be combinational and equal to the head flit of rd_vc whenever empty[rd_vc]=0 (0 when empty), and an accepted read SHALL pop that flit (latency 0).
REQ-030 Without VC_BUFFER_FWFT_EN, the registered-output behaviour of REQ-022 SHALL apply; all other requirements are identical in both builds.

Verification (DATA_WIDTH=8, RAM_DEPTH=8, NUM_VC=2, default build unless stated)
REQ-031 Fill and drain: write 0x04..0x0B to VC0, then a 9th write 0x0C -> full[0]=1 after the 8th write, 0x0C dropped, ovf_err=1; 8 reads -> data_out 0x04..0x0B in order, empty[0]=1, 8 credit_out[0] pulses.
REQ-032 VC isolation: write 0xA0 to VC1 and 0x10 to VC0 alternately, 3 each; read VC1 three times -> 0xA0,0xA1,0xA2; count VC0=3 and VC1=0; full[1] and empty[0] never asserted.
REQ-033 Simultaneous access: VC0 holds 4 flits; write 0x55 and read VC0 in the same cycle -> count stays 4, oldest flit returned, 0x55 becomes 5th-read data.
REQ-034 Empty and full boundaries: write and read of empty VC1 in the same cycle -> read rejected, udf_err=1, count[1]=1; full VC0 with write and read in the same cycle -> write dropped, ovf_err=1, count[0]=7.
REQ-035 Wrap and reset: perform 20 write/read pairs on VC0, pointers wrap, data intact; assert rst=0 with 3 flits stored -> empty=2'b11, count=0, data_out=0, error flags 0 immediately, without a clock edge.
REQ-036 FWFT build: write 0x33 to VC0 -> data_out=0x33 with rd_vc=0 and no rd_en; read -> next head visible in the same cycle as the pop edge completes.
